// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants for the ALU/branch reservation station: op codes, ROB tag width, RS geometry.
// Imported by the scheduler top, its select logic and the bench.
package alu_rs_scheduler_pkg;

    localparam int OP_LOG  = 5;
    localparam int ROB_LOG = 4;
    localparam int RS_SIZE = 16;
    localparam int RS_LOG  = 4;

    localparam logic [OP_LOG-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_LOG-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_LOG-1:0] OP_ADDI = 5'd2;
    localparam logic [OP_LOG-1:0] OP_SUB  = 5'd3;

endpackage

// File: rtl/alu_rs_scheduler_rs_select.sv
// Purpose: pick lowest free RS slot and the ready slot to issue (RS_AGE_PRIO_EN: oldest-ready-first).
// Latency: purely combinational, evaluated on registered entry state.
// Backpressure: none; callers qualify the results with the found flags.
module rs_select
    import alu_rs_scheduler_pkg::*;
(
    input  logic [RS_SIZE-1:0]        busy,
    input  logic [RS_SIZE-1:0]        ready,
`ifdef RS_AGE_PRIO_EN
    input  logic [RS_SIZE*RS_LOG-1:0] age,
`endif
    output logic                      free_found,
    output logic [RS_LOG-1:0]         free_idx,
    output logic                      issue_found,
    output logic [RS_LOG-1:0]         issue_idx
);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = RS_LOG'(i);
            end
        end
    end

`ifdef RS_AGE_PRIO_EN
    logic [RS_LOG-1:0] best_age;

    // Strict greater-than keeps the lowest index on equal (e.g. saturated) ages.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        best_age    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!issue_found || age[i*RS_LOG +: RS_LOG] > best_age)) begin
                issue_found = 1'b1;
                issue_idx   = RS_LOG'(i);
                best_age    = age[i*RS_LOG +: RS_LOG];
            end
        end
    end
`else
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = RS_LOG'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs_scheduler.sv
// Purpose: ALU/branch reservation station; CDB wakeup, dispatch bypass, one issue per cycle (RS_AGE_PRIO_EN: age select).
// Latency: dispatch-to-issue 2 cycles for ready ops; wakeup-to-issue output 2 cycles.
// Backpressure: rs_full drops dispatch; rdy=0 freezes everything; the FU never stalls issue.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               clear,
    input  logic               disp_valid,
    input  logic [OP_LOG-1:0]  disp_op,
    input  logic               disp_Qj_busy,
    input  logic [ROB_LOG-1:0] disp_Qj,
    input  logic [31:0]        disp_Vj,
    input  logic               disp_Qk_busy,
    input  logic [ROB_LOG-1:0] disp_Qk,
    input  logic [31:0]        disp_Vk,
    input  logic [31:0]        disp_Imm,
    input  logic [ROB_LOG-1:0] disp_DestRob,
    input  logic [31:0]        disp_CurPC,
    output logic               rs_full,
    input  logic               alu_cdb_en,
    input  logic [ROB_LOG-1:0] alu_cdb_rob,
    input  logic [31:0]        alu_cdb_val,
    input  logic               lsb_cdb_en,
    input  logic [ROB_LOG-1:0] lsb_cdb_rob,
    input  logic [31:0]        lsb_cdb_val,
    output logic               RS_valid,
    output logic [OP_LOG-1:0]  RS_op,
    output logic [31:0]        RS_Vj,
    output logic [31:0]        RS_Vk,
    output logic [31:0]        RS_Imm,
    output logic [ROB_LOG-1:0] RS_DestRob,
    output logic [31:0]        RS_CurPC
);

    logic [RS_SIZE-1:0] busy, qj_busy, qk_busy, ready;
    logic [OP_LOG-1:0]  e_op   [RS_SIZE];
    logic [ROB_LOG-1:0] e_qj   [RS_SIZE];
    logic [ROB_LOG-1:0] e_qk   [RS_SIZE];
    logic [ROB_LOG-1:0] e_dest [RS_SIZE];
    logic [31:0]        e_vj   [RS_SIZE];
    logic [31:0]        e_vk   [RS_SIZE];
    logic [31:0]        e_imm  [RS_SIZE];
    logic [31:0]        e_pc   [RS_SIZE];

    logic              free_found, issue_found;
    logic [RS_LOG-1:0] free_idx, issue_idx;
    logic              d_qj_busy, d_qk_busy;
    logic [31:0]       d_vj, d_vk;

    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign rs_full = &busy;

`ifdef RS_AGE_PRIO_EN
    logic [RS_LOG-1:0]         e_age [RS_SIZE];
    logic [RS_SIZE*RS_LOG-1:0] age_flat;

    always_comb begin
        age_flat = '0;
        for (int i = 0; i < RS_SIZE; i++) age_flat[i*RS_LOG +: RS_LOG] = e_age[i];
    end
`endif

    rs_select u_select (
        .busy        (busy),
        .ready       (ready),
`ifdef RS_AGE_PRIO_EN
        .age         (age_flat),
`endif
        .free_found  (free_found),
        .free_idx    (free_idx),
        .issue_found (issue_found),
        .issue_idx   (issue_idx)
    );

    // Operands whose producer broadcasts in the dispatch cycle are captured directly.
    always_comb begin
        d_qj_busy = disp_Qj_busy;
        d_vj      = disp_Vj;
        d_qk_busy = disp_Qk_busy;
        d_vk      = disp_Vk;
        if (disp_Qj_busy && alu_cdb_en && alu_cdb_rob == disp_Qj) begin
            d_qj_busy = 1'b0;
            d_vj      = alu_cdb_val;
        end else if (disp_Qj_busy && lsb_cdb_en && lsb_cdb_rob == disp_Qj) begin
            d_qj_busy = 1'b0;
            d_vj      = lsb_cdb_val;
        end
        if (disp_Qk_busy && alu_cdb_en && alu_cdb_rob == disp_Qk) begin
            d_qk_busy = 1'b0;
            d_vk      = alu_cdb_val;
        end else if (disp_Qk_busy && lsb_cdb_en && lsb_cdb_rob == disp_Qk) begin
            d_qk_busy = 1'b0;
            d_vk      = lsb_cdb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            qj_busy    <= '0;
            qk_busy    <= '0;
            RS_valid   <= 1'b0;
            RS_op      <= OP_NOP;
            RS_Vj      <= '0;
            RS_Vk      <= '0;
            RS_Imm     <= '0;
            RS_DestRob <= '0;
            RS_CurPC   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_op[i]   <= OP_NOP;
                e_qj[i]   <= '0;
                e_qk[i]   <= '0;
                e_dest[i] <= '0;
                e_vj[i]   <= '0;
                e_vk[i]   <= '0;
                e_imm[i]  <= '0;
                e_pc[i]   <= '0;
`ifdef RS_AGE_PRIO_EN
                e_age[i]  <= '0;
`endif
            end
        end else if (clear) begin
            busy     <= '0;
            RS_valid <= 1'b0;
            RS_op    <= OP_NOP;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && qj_busy[i]) begin
                    if (alu_cdb_en && alu_cdb_rob == e_qj[i]) begin
                        qj_busy[i] <= 1'b0;
                        e_vj[i]    <= alu_cdb_val;
                    end else if (lsb_cdb_en && lsb_cdb_rob == e_qj[i]) begin
                        qj_busy[i] <= 1'b0;
                        e_vj[i]    <= lsb_cdb_val;
                    end
                end
                if (busy[i] && qk_busy[i]) begin
                    if (alu_cdb_en && alu_cdb_rob == e_qk[i]) begin
                        qk_busy[i] <= 1'b0;
                        e_vk[i]    <= alu_cdb_val;
                    end else if (lsb_cdb_en && lsb_cdb_rob == e_qk[i]) begin
                        qk_busy[i] <= 1'b0;
                        e_vk[i]    <= lsb_cdb_val;
                    end
                end
`ifdef RS_AGE_PRIO_EN
                if (busy[i] && e_age[i] != '1) e_age[i] <= e_age[i] + 1'b1;
`endif
            end

            if (issue_found) begin
                RS_valid        <= 1'b1;
                RS_op           <= e_op[issue_idx];
                RS_Vj           <= e_vj[issue_idx];
                RS_Vk           <= e_vk[issue_idx];
                RS_Imm          <= e_imm[issue_idx];
                RS_DestRob      <= e_dest[issue_idx];
                RS_CurPC        <= e_pc[issue_idx];
                busy[issue_idx] <= 1'b0;
            end else begin
                RS_valid <= 1'b0;
                RS_op    <= OP_NOP;
            end

            // free_idx comes from registered busy, so a slot issued this edge is never reused here.
            if (disp_valid && free_found) begin
                busy[free_idx]    <= 1'b1;
                e_op[free_idx]    <= disp_op;
                qj_busy[free_idx] <= d_qj_busy;
                e_qj[free_idx]    <= disp_Qj;
                e_vj[free_idx]    <= d_vj;
                qk_busy[free_idx] <= d_qk_busy;
                e_qk[free_idx]    <= disp_Qk;
                e_vk[free_idx]    <= d_vk;
                e_imm[free_idx]   <= disp_Imm;
                e_dest[free_idx]  <= disp_DestRob;
                e_pc[free_idx]    <= disp_CurPC;
`ifdef RS_AGE_PRIO_EN
                e_age[free_idx]   <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler; expected issue bundles are queued at dispatch and
// popped by a negedge monitor, while each test task checks its own timing points inline.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n, rdy, clear, disp_valid;
    logic [OP_LOG-1:0]  disp_op;
    logic               disp_Qj_busy, disp_Qk_busy;
    logic [ROB_LOG-1:0] disp_Qj, disp_Qk, disp_DestRob;
    logic [31:0]        disp_Vj, disp_Vk, disp_Imm, disp_CurPC;
    logic               rs_full;
    logic               alu_cdb_en, lsb_cdb_en;
    logic [ROB_LOG-1:0] alu_cdb_rob, lsb_cdb_rob;
    logic [31:0]        alu_cdb_val, lsb_cdb_val;
    logic               RS_valid;
    logic [OP_LOG-1:0]  RS_op;
    logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
    logic [ROB_LOG-1:0] RS_DestRob;

    typedef struct {
        logic [OP_LOG-1:0]  op;
        logic [31:0]        vj;
        logic [31:0]        vk;
        logic [31:0]        imm;
        logic [ROB_LOG-1:0] dest;
        logic [31:0]        pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rdy_at_edge = 1'b0;

    always #5 clk = ~clk;

    alu_rs_scheduler dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_Qj_busy(disp_Qj_busy), .disp_Qj(disp_Qj), .disp_Vj(disp_Vj),
        .disp_Qk_busy(disp_Qk_busy), .disp_Qk(disp_Qk), .disp_Vk(disp_Vk),
        .disp_Imm(disp_Imm), .disp_DestRob(disp_DestRob), .disp_CurPC(disp_CurPC),
        .rs_full(rs_full),
        .alu_cdb_en(alu_cdb_en), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
        .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
        .RS_Imm(RS_Imm), .RS_DestRob(RS_DestRob), .RS_CurPC(RS_CurPC)
    );

    always @(posedge clk) rdy_at_edge = rdy;

    // A held RS_valid during a freeze is not a new issue, so only edges with rdy=1 count.
    always @(negedge clk) begin
        if (rst_n && RS_valid && rdy_at_edge) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got issue dest=%0d op=%0d, required no issue", RS_DestRob, RS_op);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC} !== {e.op, e.vj, e.vk, e.imm, e.dest, e.pc}) begin
                    errors++;
                    $display("FAIL issue_bundle: got op=%0d vj=%h vk=%h imm=%h dest=%0d pc=%h, required op=%0d vj=%h vk=%h imm=%h dest=%0d pc=%h",
                             RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC, e.op, e.vj, e.vk, e.imm, e.dest, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [OP_LOG-1:0] op, input logic qjb, input logic [ROB_LOG-1:0] qj,
                              input logic [31:0] vj, input logic qkb, input logic [ROB_LOG-1:0] qk,
                              input logic [31:0] vk, input logic [31:0] imm, input logic [ROB_LOG-1:0] dest,
                              input logic [31:0] pc);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_Qj_busy = qjb;
        disp_Qj      = qj;
        disp_Vj      = vj;
        disp_Qk_busy = qkb;
        disp_Qk      = qk;
        disp_Vk      = vk;
        disp_Imm     = imm;
        disp_DestRob = dest;
        disp_CurPC   = pc;
    endtask

    task automatic push_exp(input logic [OP_LOG-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [ROB_LOG-1:0] dest, input logic [31:0] pc);
        exp_t e;
        e.op = op; e.vj = vj; e.vk = vk; e.imm = imm; e.dest = dest; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic alu_bcast(input logic [ROB_LOG-1:0] tag, input logic [31:0] val);
        alu_cdb_en  = 1'b1;
        alu_cdb_rob = tag;
        alu_cdb_val = val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0;
        drive_disp(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        alu_cdb_en = 1'b0; alu_cdb_rob = '0; alu_cdb_val = '0;
        lsb_cdb_en = 1'b0; lsb_cdb_rob = '0; lsb_cdb_val = '0;
        #12;
        checks++;
        if ({RS_valid, RS_op, rs_full} !== {1'b0, OP_NOP, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b op=%0d full=%b, required 0/%0d/0", RS_valid, RS_op, rs_full, OP_NOP);
        end
        checks++;
        if ({RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC} !== '0) begin
            errors++;
            $display("FAIL reset_data: got vj=%h vk=%h imm=%h dest=%0d pc=%h, required all zero", RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ready_issue();
        drive_disp(OP_ADDI, 0, 0, 32'd5, 0, 0, 32'd0, 32'd3, 4'd2, 32'h100);
        push_exp(OP_ADDI, 32'd5, 32'd0, 32'd3, 4'd2, 32'h100);
        tick();
        disp_valid = 1'b0;
        checks++;
        if (RS_valid !== 1'b0) begin errors++; $display("FAIL t1_early: got valid=%b, required 0", RS_valid); end
        tick();
        checks++;
        if ({RS_valid, RS_op, RS_Vj, RS_DestRob} !== {1'b1, OP_ADDI, 32'd5, 4'd2}) begin
            errors++;
            $display("FAIL t1_issue: got valid=%b op=%0d vj=%0d dest=%0d, required 1/%0d/5/2", RS_valid, RS_op, RS_Vj, RS_DestRob, OP_ADDI);
        end
        tick();
        checks++;
        if ({RS_valid, RS_op} !== {1'b0, OP_NOP}) begin
            errors++;
            $display("FAIL t1_pulse: got valid=%b op=%0d, required 0/%0d", RS_valid, RS_op, OP_NOP);
        end
    endtask

    task automatic test_wakeup();
        drive_disp(OP_ADD, 1, 4'd7, 32'd0, 0, 0, 32'd1, 32'd0, 4'd3, 32'h104);
        push_exp(OP_ADD, 32'h10, 32'd1, 32'd0, 4'd3, 32'h104);
        tick();
        disp_valid = 1'b0;
        idle(2);
        alu_bcast(4'd7, 32'h10);
        tick();
        alu_cdb_en = 1'b0;
        checks++;
        if (RS_valid !== 1'b0) begin errors++; $display("FAIL t2_early: got valid=%b, required 0", RS_valid); end
        tick();
        checks++;
        if ({RS_valid, RS_Vj, RS_Vk} !== {1'b1, 32'h10, 32'd1}) begin
            errors++;
            $display("FAIL t2_issue: got valid=%b vj=%h vk=%h, required 1/10/1", RS_valid, RS_Vj, RS_Vk);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive_disp(OP_SUB, 0, 0, 32'd9, 1, 4'd4, 32'd0, 32'd0, 4'd5, 32'h108);
        lsb_cdb_en = 1'b1; lsb_cdb_rob = 4'd4; lsb_cdb_val = 32'hFF;
        push_exp(OP_SUB, 32'd9, 32'hFF, 32'd0, 4'd5, 32'h108);
        tick();
        disp_valid = 1'b0;
        lsb_cdb_en = 1'b0;
        tick();
        checks++;
        if ({RS_valid, RS_Vk} !== {1'b1, 32'hFF}) begin
            errors++;
            $display("FAIL t3_bypass: got valid=%b vk=%h, required 1/ff", RS_valid, RS_Vk);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_disp(OP_ADD, 1, 4'd9, 32'd0, 0, 0, 32'(i), 32'(i * 3), 4'(i), 32'h200 + 32'(i * 4));
            push_exp(OP_ADD, 32'hCAFE, 32'(i), 32'(i * 3), 4'(i), 32'h200 + 32'(i * 4));
            tick();
        end
        checks++;
        if (rs_full !== 1'b1) begin errors++; $display("FAIL t4_full: got rs_full=%b, required 1", rs_full); end
        drive_disp(OP_ADDI, 0, 0, 32'd1, 0, 0, 32'd1, 32'd1, 4'd15, 32'hDEAD);
        tick();
        disp_valid = 1'b0;
        alu_bcast(4'd9, 32'hCAFE);
        tick();
        alu_cdb_en = 1'b0;
        checks++;
        if ({rs_full, RS_valid} !== 2'b10) begin
            errors++;
            $display("FAIL t4_woken: got full=%b valid=%b, required 1/0", rs_full, RS_valid);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            checks++;
            if ({RS_valid, rs_full, RS_DestRob} !== {1'b1, 1'b0, 4'(i)}) begin
                errors++;
                $display("FAIL t4_drain[%0d]: got valid=%b full=%b dest=%0d, required 1/0/%0d", i, RS_valid, rs_full, RS_DestRob, i);
            end
        end
        tick();
        checks++;
        if (RS_valid !== 1'b0) begin errors++; $display("FAIL t4_empty: got valid=%b, required 0", RS_valid); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            drive_disp(OP_ADD, 1, 4'd11, 32'd0, 0, 0, 32'd2, 32'd0, 4'(i), 32'h300);
            tick();
        end
        drive_disp(OP_ADDI, 0, 0, 32'd7, 0, 0, 32'd0, 32'd1, 4'd8, 32'h304);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        disp_valid = 1'b0;
        checks++;
        if ({RS_valid, RS_op, rs_full} !== {1'b0, OP_NOP, 1'b0}) begin
            errors++;
            $display("FAIL t5_clear: got valid=%b op=%0d full=%b, required 0/%0d/0", RS_valid, RS_op, rs_full, OP_NOP);
        end
        alu_bcast(4'd11, 32'h55);
        tick();
        alu_cdb_en = 1'b0;
        idle(4);
    endtask

    task automatic test_priority();
        drive_disp(OP_ADD, 1, 4'd1, 0, 0, 0, 32'd0, 0, 4'd10, 32'h400); tick();
        drive_disp(OP_ADD, 1, 4'd2, 0, 0, 0, 32'd1, 0, 4'd11, 32'h404); tick();
        drive_disp(OP_ADD, 1, 4'd3, 0, 0, 0, 32'd2, 0, 4'd12, 32'h408); tick();
        drive_disp(OP_ADD, 1, 4'd5, 0, 0, 0, 32'd3, 0, 4'd13, 32'h40C); tick();
        disp_valid = 1'b0;
        alu_bcast(4'd2, 32'h22);
        push_exp(OP_ADD, 32'h22, 32'd1, 0, 4'd11, 32'h404);
        tick();
        alu_cdb_en = 1'b0;
        tick();
        drive_disp(OP_ADD, 1, 4'd5, 0, 0, 0, 32'd4, 0, 4'd14, 32'h410);
        tick();
        disp_valid = 1'b0;
        alu_bcast(4'd5, 32'h55);
`ifdef RS_AGE_PRIO_EN
        push_exp(OP_ADD, 32'h55, 32'd3, 0, 4'd13, 32'h40C);
        push_exp(OP_ADD, 32'h55, 32'd4, 0, 4'd14, 32'h410);
`else
        push_exp(OP_ADD, 32'h55, 32'd4, 0, 4'd14, 32'h410);
        push_exp(OP_ADD, 32'h55, 32'd3, 0, 4'd13, 32'h40C);
`endif
        tick();
        alu_cdb_en = 1'b0;
        tick();
        checks++;
`ifdef RS_AGE_PRIO_EN
        if ({RS_valid, RS_DestRob} !== {1'b1, 4'd13}) begin
            errors++; $display("FAIL t6_first: got valid=%b dest=%0d, required 1/13", RS_valid, RS_DestRob);
        end
`else
        if ({RS_valid, RS_DestRob} !== {1'b1, 4'd14}) begin
            errors++; $display("FAIL t6_first: got valid=%b dest=%0d, required 1/14", RS_valid, RS_DestRob);
        end
`endif
        tick();
        checks++;
`ifdef RS_AGE_PRIO_EN
        if ({RS_valid, RS_DestRob} !== {1'b1, 4'd14}) begin
            errors++; $display("FAIL t6_second: got valid=%b dest=%0d, required 1/14", RS_valid, RS_DestRob);
        end
`else
        if ({RS_valid, RS_DestRob} !== {1'b1, 4'd13}) begin
            errors++; $display("FAIL t6_second: got valid=%b dest=%0d, required 1/13", RS_valid, RS_DestRob);
        end
`endif
        do_clear();
    endtask

    task automatic test_freeze();
        drive_disp(OP_ADD, 1, 4'd13, 0, 0, 0, 32'd0, 0, 4'd1, 32'h500); tick();
        drive_disp(OP_ADDI, 0, 0, 32'd6, 0, 0, 32'd0, 32'd2, 4'd6, 32'h504);
        push_exp(OP_ADDI, 32'd6, 32'd0, 32'd2, 4'd6, 32'h504);
        tick();
        disp_valid = 1'b0;
        tick();
        rdy = 1'b0;
        drive_disp(OP_ADDI, 0, 0, 32'd1, 0, 0, 32'd0, 32'd0, 4'd9, 32'h508);
        alu_bcast(4'd13, 32'h13);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({RS_valid, RS_DestRob, RS_Vj} !== {1'b1, 4'd6, 32'd6}) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: got valid=%b dest=%0d vj=%0d, required 1/6/6", i, RS_valid, RS_DestRob, RS_Vj);
            end
        end
        rdy = 1'b1;
        disp_valid = 1'b0;
        alu_cdb_en = 1'b0;
        tick();
        checks++;
        if (RS_valid !== 1'b0) begin errors++; $display("FAIL freeze_release: got valid=%b, required 0", RS_valid); end
        idle(4);
        do_clear();
    endtask

    task automatic test_async_reset();
        drive_disp(OP_ADDI, 0, 0, 32'd3, 0, 0, 32'd0, 32'd4, 4'd7, 32'h600);
        push_exp(OP_ADDI, 32'd3, 32'd0, 32'd4, 4'd7, 32'h600);
        tick();
        drive_disp(OP_ADDI, 0, 0, 32'd8, 0, 0, 32'd0, 32'd0, 4'd8, 32'h604);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({RS_valid, RS_op, RS_DestRob, RS_Vj, rs_full} !== {1'b0, OP_NOP, 4'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b op=%0d dest=%0d vj=%0d full=%b, required 0/%0d/0/0/0",
                     RS_valid, RS_op, RS_DestRob, RS_Vj, rs_full, OP_NOP);
        end
        #1 rst_n = 1'b1;
        idle(4);
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_priority();
        test_freeze();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending issues, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
